// File: rtl/bus_demux_4_16_if.sv
// Handshake bundle for the 1-to-4 registered demultiplexer: one producer-side
// valid/ready word with a 2-bit destination, four consumer-side channels,
// and the aggregate busy flag.
interface bus_demux_4_16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_select;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out_data_0;
    logic [WIDTH-1:0] out_data_1;
    logic [WIDTH-1:0] out_data_2;
    logic [WIDTH-1:0] out_data_3;

    logic             out_valid_0;
    logic             out_valid_1;
    logic             out_valid_2;
    logic             out_valid_3;

    logic             out_ready_0;
    logic             out_ready_1;
    logic             out_ready_2;
    logic             out_ready_3;

    logic             busy;

    // Environment side: produces words and drives the consumers' ready lines.
    modport master (
        output in_data, in_select, in_valid,
        output out_ready_0, out_ready_1, out_ready_2, out_ready_3,
        input  in_ready,
        input  out_data_0, out_data_1, out_data_2, out_data_3,
        input  out_valid_0, out_valid_1, out_valid_2, out_valid_3,
        input  busy
    );

    // Demultiplexer side.
    modport slave (
        input  in_data, in_select, in_valid,
        input  out_ready_0, out_ready_1, out_ready_2, out_ready_3,
        output in_ready,
        output out_data_0, out_data_1, out_data_2, out_data_3,
        output out_valid_0, out_valid_1, out_valid_2, out_valid_3,
        output busy
    );
endinterface

// File: rtl/bus_demux_4_16.sv
// 1-to-4 registered demultiplexer with valid/ready handshake.
// Each destination channel owns a one-entry holding register, so a stalled
// consumer only blocks words addressed to its own channel. in_ready looks at
// the selected channel alone; the data path is fully registered.
module bus_demux_4_16 #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic            clk,
    input  logic            reset,
    bus_demux_4_16_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [4];
    chan_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];

    logic [3:0]       out_ready_v;
    logic [3:0]       out_valid_v;
    logic             in_ready_c;
    logic             accept_c;

    assign out_ready_v = {bus.out_ready_3, bus.out_ready_2,
                          bus.out_ready_1, bus.out_ready_0};

    // Handshake on the producer side: the selected slot must be empty or draining now.
    always_comb begin
        in_ready_c = 1'b0;
        accept_c   = 1'b0;
        in_ready_c = (state_q[bus.in_select] == EMPTY) || out_ready_v[bus.in_select];
        accept_c   = bus.in_valid && in_ready_c;
    end

    // Per-channel next state and holding-register load; unselected channels keep their word.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            data_d[n]  = data_q[n];
            case (state_q[n])
                EMPTY: begin
                    if (accept_c && (bus.in_select == 2'(n))) begin
                        state_d[n] = FULL;
                        data_d[n]  = bus.in_data;
                    end
                end
                FULL: begin
                    // A load into a full slot implies its consumer is taking the old word now.
                    if (accept_c && (bus.in_select == 2'(n))) begin
                        state_d[n] = FULL;
                        data_d[n]  = bus.in_data;
                    end else if (out_ready_v[n]) begin
                        state_d[n] = EMPTY;
                    end
                end
                default: begin
                    state_d[n] = EMPTY;
                end
            endcase
        end
    end

    // Channel registers; reset discards every held word and restores the reset pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= EMPTY;
                data_q[n]  <= RESET_DATA;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                data_q[n]  <= data_d[n];
            end
        end
    end

    assign out_valid_v = {state_q[3] == FULL, state_q[2] == FULL,
                          state_q[1] == FULL, state_q[0] == FULL};

    assign bus.in_ready    = in_ready_c;

    assign bus.out_valid_0 = out_valid_v[0];
    assign bus.out_valid_1 = out_valid_v[1];
    assign bus.out_valid_2 = out_valid_v[2];
    assign bus.out_valid_3 = out_valid_v[3];

    assign bus.out_data_0  = data_q[0];
    assign bus.out_data_1  = data_q[1];
    assign bus.out_data_2  = data_q[2];
    assign bus.out_data_3  = data_q[3];

    assign bus.busy        = |out_valid_v;

`ifndef SYNTHESIS
    // An unknown destination on a presented word would route to an arbitrary channel.
    a_select_known: assert property (@(posedge clk) disable iff (reset)
        bus.in_valid |-> !$isunknown(bus.in_select));
`endif

endmodule

// File: tb/tb_bus_demux_4_16.sv
// Self-checking bench for bus_demux_4_16: directed scenarios followed by a
// randomized run, all checked against a per-channel queue model.
module tb_bus_demux_4_16;

    logic        clk;
    logic        reset;
    logic [3:0]  ordy;
    logic [3:0]  ov;
    logic [15:0] od [4];

    int n_checks;
    int n_fail;
    bit last_acc;

    // Reference model: words accepted for each channel and not yet taken by
    // its consumer, plus the last word ever written to each channel.
    logic [15:0] sb [4][$];
    logic [15:0] last_data [4];

    bus_demux_4_16_if #(.WIDTH(16)) bus ();

    bus_demux_4_16 #(
        .WIDTH      (16),
        .RESET_DATA (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.out_ready_0 = ordy[0];
    assign bus.out_ready_1 = ordy[1];
    assign bus.out_ready_2 = ordy[2];
    assign bus.out_ready_3 = ordy[3];

    assign ov    = {bus.out_valid_3, bus.out_valid_2, bus.out_valid_1, bus.out_valid_0};
    assign od[0] = bus.out_data_0;
    assign od[1] = bus.out_data_1;
    assign od[2] = bus.out_data_2;
    assign od[3] = bus.out_data_3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            sb[n].delete();
            last_data[n] = 16'h0000;
        end
    endtask

    // One clock with inputs already applied: check in_ready and delivered
    // words before the edge, advance the model, check outputs after the edge.
    task automatic cycle();
        logic        exp_ready;
        logic        acc;
        logic        any_full;
        logic [3:0]  dlv;
        logic [1:0]  s;
        logic [15:0] d;
        #1;
        s         = bus.in_select;
        d         = bus.in_data;
        exp_ready = (sb[s].size() == 0) || ordy[s];
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
        acc = bus.in_valid && exp_ready;
        for (int n = 0; n < 4; n++) begin
            dlv[n] = (sb[n].size() != 0) && ordy[n];
            if (dlv[n])
                check($sformatf("deliver_%0d", n), {16'b0, od[n]}, {16'b0, sb[n][0]});
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++)
            if (dlv[n]) void'(sb[n].pop_front());
        if (acc) begin
            sb[s].push_back(d);
            last_data[s] = d;
        end
        any_full = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("out_valid_%0d", n), {31'b0, ov[n]}, {31'b0, sb[n].size() != 0});
            check($sformatf("out_data_%0d", n), {16'b0, od[n]}, {16'b0, last_data[n]});
            if (sb[n].size() > 1) check($sformatf("depth_%0d", n), sb[n].size(), 1);
            if (sb[n].size() != 0) any_full = 1'b1;
        end
        check("busy", {31'b0, bus.busy}, {31'b0, any_full});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        last_acc      = 1'b1;
        reset         = 1'b1;
        ordy          = 4'h0;
        bus.in_valid  = 1'b0;
        bus.in_select = 2'd0;
        bus.in_data   = 16'h0000;
        model_reset();

        // Power-on reset state
        #2;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("rst_valid_%0d", n), {31'b0, ov[n]}, 32'd0);
            check($sformatf("rst_data_%0d", n), {16'b0, od[n]}, 32'h0000);
        end
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Asynchronous reset with channel 2 holding 0xBEEF
        bus.in_data   = 16'hBEEF;
        bus.in_select = 2'd2;
        bus.in_valid  = 1'b1;
        cycle();
        bus.in_valid  = 1'b0;
        check("pre_rst_data_2", {16'b0, od[2]}, 32'hBEEF);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid_2", {31'b0, ov[2]}, 32'd0);
        check("async_rst_data_2", {16'b0, od[2]}, 32'h0000);
        check("async_rst_busy", {31'b0, bus.busy}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single route to channel 1
        bus.in_data   = 16'h1234;
        bus.in_select = 2'd1;
        bus.in_valid  = 1'b1;
        cycle();
        check("route_valid_1", {31'b0, ov[1]}, 32'd1);
        check("route_data_1", {16'b0, od[1]}, 32'h1234);
        check("route_others", {28'b0, ov}, 32'h2);

        // Backpressure on channel 1 leaves other channels open
        bus.in_data   = 16'h5555;
        bus.in_select = 2'd1;
        cycle();
        check("bp_data_1", {16'b0, od[1]}, 32'h1234);
        bus.in_valid  = 1'b0;
        cycle();
        bus.in_data   = 16'h7777;
        bus.in_select = 2'd3;
        bus.in_valid  = 1'b1;
        cycle();
        check("bp_data_3", {16'b0, od[3]}, 32'h7777);
        check("bp_hold_1", {16'b0, od[1]}, 32'h1234);

        // Back-to-back pass-through on channel 0
        bus.in_data   = 16'h00AA;
        bus.in_select = 2'd0;
        cycle();
        ordy[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.in_data = 16'(i);
            cycle();
            check("pt_valid_0", {31'b0, ov[0]}, 32'd1);
            check("pt_data_0", {16'b0, od[0]}, i);
        end
        bus.in_valid = 1'b0;
        cycle();
        ordy[0] = 1'b0;

        // Fill all four, then drain everything in one cycle
        bus.in_valid  = 1'b1;
        bus.in_select = 2'd0;
        bus.in_data   = 16'h00A0;
        cycle();
        bus.in_select = 2'd2;
        bus.in_data   = 16'h00A2;
        cycle();
        bus.in_valid  = 1'b0;
        check("fill_all", {28'b0, ov}, 32'hF);
        ordy = 4'hF;
        cycle();
        check("drain_all", {28'b0, ov}, 32'h0);
        check("drain_busy", {31'b0, bus.busy}, 32'd0);
        ordy = 4'h0;

        // Randomized traffic; a stalled word is held until accepted
        last_acc = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if (!(bus.in_valid && !last_acc)) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_select = 2'($urandom_range(0, 3));
                bus.in_data   = 16'($urandom);
            end
            ordy = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
